rgb_avg_filter: RTL and testbench



---
 rtl/rgb_avg_filter.sv | 155 +++++++++++++++
 tb/tb_rgb_avg_filter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_avg_filter.sv
// Sliding-window RGB averager with a one-cycle update strobe for the WS2812 path.
// Define RGB_HYST_EN to suppress updates whose per-channel change is below THRESH.
module rgb_avg_filter #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned THRESH     = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_valid
);

    localparam int unsigned WIN = 1 << DEPTH_LOG2;
    localparam int unsigned SW  = 8 + DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   WIN_CNT  = (DEPTH_LOG2 + 1)'(WIN);
    localparam logic [DEPTH_LOG2:0]   FILL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] WPTR_ONE = 1;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic [7:0]            in_ch   [3];
    logic [7:0]            old_ch  [3];
    logic [7:0]            avg     [3];
    logic [7:0]            buf_mem [3][WIN];
    logic [SW-1:0]         sum_q   [3];
    logic [SW-1:0]         sum_d   [3];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2:0]   fill_cnt;
    logic                  s1_valid;
    logic                  state;
    logic                  state_next;
    logic                  upd;
    logic                  big_change;

    assign in_ch[0] = in_r;
    assign in_ch[1] = in_g;
    assign in_ch[2] = in_b;

    // Sum is updated with the slot being overwritten, so it always equals the window total.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            old_ch[c] = buf_mem[c][wptr];
            sum_d[c]  = sum_q[c] + SW'(in_ch[c]) - SW'(old_ch[c]);
            avg[c]    = 8'(sum_q[c] >> DEPTH_LOG2);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < WIN; i++) begin
                    buf_mem[c][i] <= '0;
                end
                sum_q[c] <= '0;
            end
            wptr     <= '0;
            fill_cnt <= '0;
            s1_valid <= 1'b0;
        end else if (clr) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < WIN; i++) begin
                    buf_mem[c][i] <= '0;
                end
                sum_q[c] <= '0;
            end
            wptr     <= '0;
            fill_cnt <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int c = 0; c < 3; c++) begin
                    buf_mem[c][wptr] <= in_ch[c];
                    sum_q[c]         <= sum_d[c];
                end
                wptr <= wptr + WPTR_ONE;
                if (fill_cnt != WIN_CNT) begin
                    fill_cnt <= fill_cnt + FILL_ONE;
                end
            end
        end
    end

`ifdef RGB_HYST_EN
    logic [7:0] out_ch [3];
    logic [8:0] diff   [3];
    logic [8:0] mag    [3];

    assign out_ch[0] = out_r;
    assign out_ch[1] = out_g;
    assign out_ch[2] = out_b;

    // 9-bit signed difference cannot wrap for 8-bit operands.
    always_comb begin
        big_change = 1'b0;
        for (int c = 0; c < 3; c++) begin
            diff[c] = {1'b0, avg[c]} - {1'b0, out_ch[c]};
            mag[c]  = diff[c][8] ? (9'd0 - diff[c]) : diff[c];
            if (32'(mag[c]) >= THRESH) begin
                big_change = 1'b1;
            end
        end
    end
`else
    assign big_change = 1'b1;
`endif

    always_comb begin
        state_next = state;
        upd        = 1'b0;
        if (s1_valid) begin
            case (state)
                ST_FILL: begin
                    if (fill_cnt == WIN_CNT) begin
                        upd        = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                default: upd = big_change;
            endcase
        end
    end

    // clr discards any stage-1 decision but keeps the last presented colour.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_FILL;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= ST_FILL;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= upd;
            if (upd) begin
                out_r <= avg[0];
                out_g <= avg[1];
                out_b <= avg[2];
            end
        end
    end

endmodule

// File: tb/tb_rgb_avg_filter.sv
// Self-checking bench for rgb_avg_filter against a queue-based window-average model.
`timescale 1ns/1ps
module tb_rgb_avg_filter;

    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned THRESH     = 8;
    localparam int          WIN        = 1 << DEPTH_LOG2;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_r, in_g, in_b;
    logic [7:0] out_r, out_g, out_b;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    rgb_avg_filter #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .THRESH    (THRESH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_r     (in_r),
        .in_g     (in_g),
        .in_b     (in_b),
        .out_r    (out_r),
        .out_g    (out_g),
        .out_b    (out_b),
        .out_valid(out_valid)
    );

    // Reference model: history of accepted samples since the last clear.
    int hist_r[$];
    int hist_g[$];
    int hist_b[$];
    int accepted;
    bit running;
    bit pend;
    bit pend_full;
    int pend_avg[3];
    int exp_out[3];
    bit exp_valid;

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_clear();
        hist_r.delete();
        hist_g.delete();
        hist_b.delete();
        accepted = 0;
        running  = 0;
        pend     = 0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int c = 0; c < 3; c++) exp_out[c] = 0;
        exp_valid = 0;
    endtask

    task automatic model_edge(input bit v, input bit c, input int r, input int g, input int b);
        bit go;
        int d;
        exp_valid = 0;
        if (c) begin
            model_clear();
            return;
        end
        if (pend) begin
            go = 0;
            if (!running) begin
                if (pend_full) begin
                    go      = 1;
                    running = 1;
                end
            end else begin
`ifdef RGB_HYST_EN
                for (int ch = 0; ch < 3; ch++) begin
                    d = pend_avg[ch] - exp_out[ch];
                    if (d < 0) d = -d;
                    if (d >= int'(THRESH)) go = 1;
                end
`else
                go = 1;
`endif
            end
            if (go) begin
                for (int ch = 0; ch < 3; ch++) exp_out[ch] = pend_avg[ch];
                exp_valid = 1;
            end
        end
        pend = 0;
        if (v) begin
            hist_r.push_back(r);
            hist_g.push_back(g);
            hist_b.push_back(b);
            if (hist_r.size() > WIN) begin
                void'(hist_r.pop_front());
                void'(hist_g.pop_front());
                void'(hist_b.pop_front());
            end
            accepted++;
            pend        = 1;
            pend_full   = (accepted >= WIN);
            pend_avg[0] = qsum(hist_r) / WIN;
            pend_avg[1] = qsum(hist_g) / WIN;
            pend_avg[2] = qsum(hist_b) / WIN;
        end
    endtask

    // One clock of stimulus; returns at the following falling edge.
    task automatic step(input bit v, input bit c, input int r, input int g, input int b);
        in_valid = v;
        clr      = c;
        in_r     = 8'(r);
        in_g     = 8'(g);
        in_b     = 8'(b);
        @(posedge sys_clk);
        model_edge(v, c, r, g, b);
        @(negedge sys_clk);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [24:0] want_vec();
        return {exp_valid, 8'(exp_out[0]), 8'(exp_out[1]), 8'(exp_out[2])};
    endfunction

    task automatic test_reset();
        sys_rst  = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({out_valid, out_r, out_g, out_b} !== 25'd0) begin
            errors++;
            $display("FAIL reset: got %h required %h", {out_valid, out_r, out_g, out_b}, 25'd0);
        end
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        logic [24:0] got;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 1'b0, 40, 80, 120);
            got = {out_valid, out_r, out_g, out_b};
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL fill[%0d]: got %h required %h", i, got, want_vec());
            end
        end
        checks++;
        if (got !== {1'b1, 8'd40, 8'd80, 8'd120}) begin
            errors++;
            $display("FAIL fill_final: got %h required %h", got, {1'b1, 8'd40, 8'd80, 8'd120});
        end
    endtask

    task automatic test_hold();
        logic [24:0] got;
        logic [24:0] want;
        step(1'b1, 1'b0, 44, 80, 120);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_early: got valid %b required 0", out_valid);
        end
        step(1'b0, 1'b0, 0, 0, 0);
        got = {out_valid, out_r, out_g, out_b};
`ifdef RGB_HYST_EN
        want = {1'b0, 8'd40, 8'd80, 8'd120};
`else
        want = {1'b1, 8'd41, 8'd80, 8'd120};
`endif
        checks++;
        if (got !== want || got !== want_vec()) begin
            errors++;
            $display("FAIL hold: got %h required %h (model %h)", got, want, want_vec());
        end
    endtask

    task automatic test_threshold();
        logic [24:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 40, 80, 120);
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 72, 80, 120);
        step(1'b0, 1'b0, 0, 0, 0);
        got = {out_valid, out_r, out_g, out_b};
        checks++;
        if (got !== {1'b1, 8'd48, 8'd80, 8'd120} || got !== want_vec()) begin
            errors++;
            $display("FAIL threshold: got %h required %h", got, {1'b1, 8'd48, 8'd80, 8'd120});
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        int exp_pulses = 0;
        logic [24:0] got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(i < 6, 1'b0, 255, 255, 255);
            got = {out_valid, out_r, out_g, out_b};
            pulses += int'(out_valid);
            exp_pulses += int'(exp_valid);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h required %h", i, got, want_vec());
            end
        end
        checks++;
`ifdef RGB_HYST_EN
        if (pulses != 1 || exp_pulses != 1) begin
`else
        if (pulses != 3 || exp_pulses != 3) begin
`endif
            errors++;
            $display("FAIL saturation_pulses: got %0d required %0d", pulses, exp_pulses);
        end
        checks++;
        if ({out_r, out_g, out_b} !== {8'd255, 8'd255, 8'd255}) begin
            errors++;
            $display("FAIL saturation_out: got %h required ffffff", {out_r, out_g, out_b});
        end
    endtask

    task automatic test_clr();
        logic [24:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 40, 80, 120);
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 10, 10, 10);
        step(1'b1, 1'b0, 10, 10, 10);
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 200, 200, 200);
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 1'b0, 100, 100, 100);
            got = {out_valid, out_r, out_g, out_b};
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL clr[%0d]: got %h required %h", i, got, want_vec());
            end
            if (i < 4) begin
                checks++;
                if (got[24] !== 1'b0 || got[23:0] === {8'd100, 8'd100, 8'd100}) begin
                    errors++;
                    $display("FAIL clr_hold[%0d]: got %h required no pulse, pre-clr colour", i, got);
                end
            end
        end
        checks++;
        if (got !== {1'b1, 8'd100, 8'd100, 8'd100}) begin
            errors++;
            $display("FAIL clr_final: got %h required %h", got, {1'b1, 8'd100, 8'd100, 8'd100});
        end
    endtask

    task automatic test_async_reset();
        logic [24:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 40, 80, 120);
        step(1'b0, 1'b0, 0, 0, 0);
        in_valid = 1'b1;
        in_r = 8'd200; in_g = 8'd200; in_b = 8'd200;
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        got = {out_valid, out_r, out_g, out_b};
        checks++;
        if (got !== 25'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", got, 25'd0);
        end
        @(negedge sys_clk);
        in_valid = 1'b0;
        sys_rst  = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 0, 0);
            got = {out_valid, out_r, out_g, out_b};
            checks++;
            if (got !== 25'd0) begin
                errors++;
                $display("FAIL async_reset_after[%0d]: got %h required %h", i, got, 25'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base[3];
        int val[3];
        logic [24:0] got;
        apply_reset();
        for (int c = 0; c < 3; c++) base[c] = int'($urandom_range(0, 255));
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 15) == 0) base[c] = int'($urandom_range(0, 255));
                val[c] = base[c] + int'($urandom_range(0, 10)) - 5;
                if (val[c] < 0) val[c] = 0;
                if (val[c] > 255) val[c] = 255;
            end
            step($urandom_range(0, 9) < 7, 1'b0, val[0], val[1], val[2]);
            got = {out_valid, out_r, out_g, out_b};
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h required %h", i, got, want_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_threshold();
        test_saturation();
        test_clr();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
